// File: rtl/riscv_core_dcache_nway.sv
// riscv_core_dcache_nway: N-way set-associative, write-through, no-write-allocate
// L1 data cache with per-set round-robin replacement and a flush sequencer.
// Optional build macro DCACHE_PERF_CNT_EN adds saturating hit/miss/write counters.
module riscv_core_dcache_nway #(
   parameter int unsigned NUM_WAYS        = 2,
   parameter int unsigned NUM_SETS        = 128,
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned CORE_DATA_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH  = 256
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
   input  logic [CORE_DATA_WIDTH-1:0] i_data_from_core,
   input  logic                       i_read,
   input  logic                       i_write,
   input  logic [1:0]                 i_size,
   input  logic                       i_flush,
   output logic                       o_stall,
   output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
   output logic                       o_load_fault,
   output logic                       o_store_fault,
   output logic                       o_mem_read_req,
   output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
   input  logic                       i_mem_read_done,
   input  logic [AXI_DATA_WIDTH-1:0]  i_block_from_axi,
   output logic                       o_mem_write_valid,
   output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
   output logic [CORE_DATA_WIDTH-1:0] o_mem_write_data,
   output logic [7:0]                 o_mem_write_strobe,
`ifdef DCACHE_PERF_CNT_EN
   output logic [63:0]                o_hit_count,
   output logic [63:0]                o_miss_count,
   output logic [63:0]                o_wb_count,
`endif
   input  logic                       i_mem_write_done
);

   localparam int unsigned OFF_W      = $clog2(AXI_DATA_WIDTH / 8);
   localparam int unsigned IDX_W      = $clog2(NUM_SETS);
   localparam int unsigned TAG_W      = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int unsigned WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int unsigned DW_PER_BLK = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
   localparam int unsigned DW_SEL_W   = (DW_PER_BLK > 1) ? $clog2(DW_PER_BLK) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REFILL = 3'd1,
      S_WRITE  = 3'd2,
      S_WACK   = 3'd3,
      S_FLUSH  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
   logic [WAY_W-1:0]          rr_q    [NUM_SETS];
   logic [TAG_W-1:0]          tag_q   [NUM_WAYS][NUM_SETS];
   logic [AXI_DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS];
   logic [IDX_W-1:0]          flush_cnt_q;

   logic [TAG_W-1:0]           req_tag;
   logic [IDX_W-1:0]           req_idx;
   logic [DW_SEL_W-1:0]        dw_sel;
   logic [2:0]                 byte_off;
   logic                       misaligned;
   logic [7:0]                 wr_strobe;
   logic [CORE_DATA_WIDTH-1:0] wr_data;
   logic [NUM_WAYS-1:0]        hit_vec;
   logic [WAY_W-1:0]           hit_way;
   logic                       hit;
   logic [WAY_W-1:0]           victim;
   logic                       set_full;
   logic [WAY_W-1:0]           rr_next;
   logic [AXI_DATA_WIDTH-1:0]  hit_blk;
   logic [AXI_DATA_WIDTH-1:0]  store_blk;
   logic [CORE_DATA_WIDTH-1:0] hit_dw;
   logic                       req_flush, req_store, req_load;
   logic                       load_ok, store_ok, load_hit;

   assign req_tag  = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx  = i_addr_from_core[OFF_W +: IDX_W];
   assign byte_off = i_addr_from_core[2:0];

   // Doubleword select within the block (degenerates to 0 for single-dword blocks)
   if (DW_PER_BLK > 1) begin : g_dw_sel
      assign dw_sel = i_addr_from_core[3 +: DW_SEL_W];
   end else begin : g_dw_sel_zero
      assign dw_sel = '0;
   end

   // Request decode with flush > write > read priority, plus alignment check
   always_comb begin
      req_flush = i_flush;
      req_store = !i_flush && i_write;
      req_load  = !i_flush && !i_write && i_read;
      case (i_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = byte_off[0];
         2'b10:   misaligned = |byte_off[1:0];
         default: misaligned = |byte_off;
      endcase
      load_ok  = req_load && !misaligned;
      store_ok = req_store && !misaligned;
   end

   // Store lane shift and byte enables
   always_comb begin
      case (i_size)
         2'b00:   wr_strobe = 8'h01;
         2'b01:   wr_strobe = 8'h03;
         2'b10:   wr_strobe = 8'h0F;
         default: wr_strobe = 8'hFF;
      endcase
      wr_strobe = wr_strobe << byte_off;
      wr_data   = i_data_from_core << {byte_off, 3'b000};
   end

   // Parallel tag compare over all ways; a hit requires exactly one matching way
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         hit_vec[WAY_W'(w)] = valid_q[req_idx][WAY_W'(w)] &&
                              (tag_q[WAY_W'(w)][req_idx] == req_tag);
         if (hit_vec[WAY_W'(w)]) hit_way = WAY_W'(w);
      end
      hit     = $onehot(hit_vec);
      load_hit = load_ok && hit;
   end

   // Victim: lowest invalid way, otherwise the set's round-robin pointer
   always_comb begin
      victim   = rr_q[req_idx];
      set_full = &valid_q[req_idx];
      for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][WAY_W'(w)]) victim = WAY_W'(w);
      end
      rr_next = (rr_q[req_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[req_idx] + WAY_W'(1);
   end

   // Hit-line read and byte-merged store image
   always_comb begin
      hit_blk   = data_q[hit_way][req_idx];
      hit_dw    = '0;
      store_blk = hit_blk;
      for (int unsigned j = 0; j < DW_PER_BLK; j++) begin
         if (DW_SEL_W'(j) == dw_sel) begin
            hit_dw = hit_blk[j*64 +: 64];
            for (int unsigned k = 0; k < 8; k++) begin
               if (wr_strobe[k]) store_blk[j*64 + k*8 +: 8] = wr_data[k*8 +: 8];
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_flush)              state_d = S_FLUSH;
            else if (store_ok)          state_d = S_WRITE;
            else if (load_ok && !hit)   state_d = S_REFILL;
         end
         S_REFILL: if (i_mem_read_done)  state_d = S_IDLE;
         S_WRITE:  if (i_mem_write_done) state_d = S_WACK;
         S_WACK:   state_d = S_IDLE;
         S_FLUSH:  if (flush_cnt_q == IDX_W'(NUM_SETS - 1)) state_d = S_WACK;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs; everything forced low while reset is asserted
   always_comb begin
      o_stall             = 1'b0;
      o_data_to_core      = '0;
      o_load_fault        = 1'b0;
      o_store_fault       = 1'b0;
      o_mem_read_req      = 1'b0;
      o_mem_read_address  = '0;
      o_mem_write_valid   = 1'b0;
      o_mem_write_address = '0;
      o_mem_write_data    = '0;
      o_mem_write_strobe  = '0;
      if (!i_rst) begin
         case (state_q)
            S_IDLE: begin
               o_load_fault  = req_load && misaligned;
               o_store_fault = req_store && misaligned;
               o_stall       = req_flush || store_ok || (load_ok && !hit);
               if (load_hit) o_data_to_core = hit_dw;
            end
            S_REFILL: begin
               o_stall            = 1'b1;
               o_mem_read_req     = 1'b1;
               o_mem_read_address = {req_tag, req_idx, OFF_W'(0)};
            end
            S_WRITE: begin
               o_stall             = 1'b1;
               o_mem_write_valid   = 1'b1;
               o_mem_write_address = {i_addr_from_core[ADDR_WIDTH-1:3], 3'b000};
               o_mem_write_data    = wr_data;
               o_mem_write_strobe  = wr_strobe;
            end
            S_FLUSH: o_stall = 1'b1;
            default: ;
         endcase
      end
   end

   // Valid bits, round-robin pointers and flush counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned s = 0; s < NUM_SETS; s++) begin
            valid_q[IDX_W'(s)] <= '0;
            rr_q[IDX_W'(s)]    <= '0;
         end
         flush_cnt_q <= '0;
      end else begin
         if (state_q == S_IDLE && req_flush) flush_cnt_q <= '0;
         if (state_q == S_REFILL && i_mem_read_done) begin
            valid_q[req_idx][victim] <= 1'b1;
            if (set_full) rr_q[req_idx] <= rr_next;
         end
         if (state_q == S_FLUSH) begin
            valid_q[flush_cnt_q] <= '0;
            rr_q[flush_cnt_q]    <= '0;
            flush_cnt_q          <= flush_cnt_q + IDX_W'(1);
         end
      end
   end

   // Tag and data arrays: refill installs a block, store hit merges bytes
   always_ff @(posedge i_clk) begin
      if (state_q == S_REFILL && i_mem_read_done) begin
         data_q[victim][req_idx] <= i_block_from_axi;
         tag_q[victim][req_idx]  <= req_tag;
      end else if (state_q == S_IDLE && store_ok && hit) begin
         data_q[hit_way][req_idx] <= store_blk;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [63:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

   // Saturating event counters
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (state_q == S_IDLE && load_hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 64'd1;
         if (state_q == S_IDLE && state_d == S_REFILL && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 64'd1;
         if (state_q == S_IDLE && state_d == S_WRITE && wb_cnt_q != '1)
            wb_cnt_q <= wb_cnt_q + 64'd1;
      end
   end

   assign o_hit_count  = hit_cnt_q;
   assign o_miss_count = miss_cnt_q;
   assign o_wb_count   = wb_cnt_q;
`endif

endmodule
